// File: rtl/mips_pkg.sv
// Shared defaults and FSM encoding for the MIPS register file slice.
package mips_pkg;

    localparam int DATA_W_DEF = 32;
    localparam int ADDR_W_DEF = 5;
    localparam int REG_ZERO   = 0;

    typedef enum logic {
        S_CLEAR = 1'b0,
        S_READY = 1'b1
    } rf_state_e;

endpackage

// File: rtl/reg_scoreboard.sv
// Per-register pending bits: set by producer marks, cleared by writeback, flushed on clear.
module reg_scoreboard
    import mips_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              mark_en,
    input  logic [ADDR_W-1:0] mark_addr,
    input  logic              clr_en,
    input  logic [ADDR_W-1:0] clr_addr,
    input  logic [ADDR_W-1:0] a1,
    input  logic [ADDR_W-1:0] a2,
    output logic              pend1,
    output logic              pend2
);

    localparam int DEPTH = 1 << ADDR_W;

    logic [DEPTH-1:0] pending;
    logic [DEPTH-1:0] pending_nxt;

    // Mark is checked before the writeback clear so a same-cycle mark wins.
    for (genvar i = 0; i < DEPTH; i++) begin : g_bit
        assign pending_nxt[i] = flush                                   ? 1'b0 :
                                (mark_en && mark_addr == ADDR_W'(i))   ? 1'b1 :
                                (clr_en  && clr_addr  == ADDR_W'(i))   ? 1'b0 :
                                                                         pending[i];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) pending <= '0;
        else        pending <= pending_nxt;
    end

    assign pend1 = pending[a1];
    assign pend2 = pending[a2];

endmodule

// File: rtl/regfile_sb.sv
// 2R/1W register file with hardwired zero, write-first bypass, clear sweep and scoreboard.
module regfile_sb
    import mips_pkg::*;
#(
    parameter int DATA_W   = DATA_W_DEF,
    parameter int ADDR_W   = ADDR_W_DEF,
    parameter bit ZERO_REG = 1'b1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr_req,
    output logic              ready,
    input  logic [ADDR_W-1:0] a1,
    input  logic [ADDR_W-1:0] a2,
    output logic [DATA_W-1:0] rd1,
    output logic [DATA_W-1:0] rd2,
    output logic              rd1_busy,
    output logic              rd2_busy,
    input  logic              we,
    input  logic [ADDR_W-1:0] a3,
    input  logic [DATA_W-1:0] wd3,
    input  logic              mark_en,
    input  logic [ADDR_W-1:0] mark_addr
);

    localparam int          DEPTH = 1 << ADDR_W;
    localparam int          CNT_W = ADDR_W + 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(DEPTH - 1);

    rf_state_e         state_q, state_d;
    logic [CNT_W-1:0]  cnt;
    logic [DATA_W-1:0] mem [DEPTH];

    logic wr_ok, mark_ok, flush;
    logic z1, z2, hit1, hit2, pend1, pend2;

    assign ready = (state_q == S_READY);

    // A clear request takes priority over any write or mark in the same cycle.
    assign wr_ok   = ready && !clr_req && we &&
                     !(ZERO_REG && a3 == ADDR_W'(REG_ZERO));
    assign mark_ok = ready && !clr_req && mark_en &&
                     !(ZERO_REG && mark_addr == ADDR_W'(REG_ZERO));
    assign flush   = !ready || clr_req;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= S_CLEAR;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_CLEAR: if (cnt == LAST) state_d = S_READY;
            S_READY: if (clr_req)     state_d = S_CLEAR;
            default: state_d = S_CLEAR;
        endcase
    end

    // Counter parks at DEPTH-1 after the sweep so it never wraps.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                                cnt <= '0;
        else if (state_q == S_CLEAR && cnt != LAST) cnt <= cnt + 1'b1;
        else if (state_q == S_READY && clr_req)     cnt <= '0;
    end

    always_ff @(posedge clk) begin
        if (state_q == S_CLEAR) mem[cnt[ADDR_W-1:0]] <= '0;
        else if (wr_ok)         mem[a3]              <= wd3;
    end

    assign z1   = ZERO_REG && (a1 == ADDR_W'(REG_ZERO));
    assign z2   = ZERO_REG && (a2 == ADDR_W'(REG_ZERO));
    assign hit1 = wr_ok && (a3 == a1);
    assign hit2 = wr_ok && (a3 == a2);

    assign rd1 = (!ready || z1) ? '0 : hit1 ? wd3 : mem[a1];
    assign rd2 = (!ready || z2) ? '0 : hit2 ? wd3 : mem[a2];

    reg_scoreboard #(.ADDR_W(ADDR_W)) u_sb (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .mark_en   (mark_ok),
        .mark_addr (mark_addr),
        .clr_en    (wr_ok),
        .clr_addr  (a3),
        .a1        (a1),
        .a2        (a2),
        .pend1     (pend1),
        .pend2     (pend2)
    );

    // Bypassed data is already current, so it is never reported busy.
    assign rd1_busy = ready && pend1 && !hit1;
    assign rd2_busy = ready && pend2 && !hit2;

endmodule

// File: tb/tb_regfile_sb.sv
// Self-checking bench for regfile_sb: directed table, corner sequences, random vs model.
module tb_regfile_sb;

    localparam int DW = 32;
    localparam int AW = 5;
    localparam int DEPTH = 32;

    logic          clk, rst_n, clr_req, ready, we, mark_en;
    logic [AW-1:0] a1, a2, a3, mark_addr;
    logic [DW-1:0] rd1, rd2, wd3;
    logic          rd1_busy, rd2_busy;

    int n_chk = 0;
    int n_fail = 0;

    regfile_sb #(.DATA_W(DW), .ADDR_W(AW), .ZERO_REG(1'b1)) dut (
        .clk(clk), .rst_n(rst_n), .clr_req(clr_req), .ready(ready),
        .a1(a1), .a2(a2), .rd1(rd1), .rd2(rd2),
        .rd1_busy(rd1_busy), .rd2_busy(rd2_busy),
        .we(we), .a3(a3), .wd3(wd3),
        .mark_en(mark_en), .mark_addr(mark_addr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: array contents, pending flags, edges counted since sweep start.
    logic [DW-1:0] m_mem [DEPTH];
    bit            m_pend [DEPTH];
    bit            m_ready;
    int            m_cnt;

    typedef struct {
        logic          we;
        logic [AW-1:0] a3;
        logic [DW-1:0] wd3;
        logic [AW-1:0] a1;
        logic          mark_en;
        logic [AW-1:0] mark_addr;
        logic [DW-1:0] exp_rd1;
        logic          exp_busy1;
    } vec_t;

    task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic bit m_wr_valid();
        return m_ready && !clr_req && we && (a3 != 0);
    endfunction

    function automatic logic [DW-1:0] m_rd(input logic [AW-1:0] a);
        if (!m_ready || a == 0) return '0;
        if (m_wr_valid() && a3 == a) return wd3;
        return m_mem[a];
    endfunction

    function automatic logic m_busy(input logic [AW-1:0] a);
        return m_ready && m_pend[a] && !(m_wr_valid() && a3 == a);
    endfunction

    task automatic model_reset();
        m_ready = 0;
        m_cnt = 0;
        foreach (m_pend[i]) m_pend[i] = 0;
    endtask

    task automatic model_edge();
        if (!m_ready) begin
            m_cnt++;
            if (m_cnt == DEPTH) begin
                m_ready = 1;
                foreach (m_mem[i]) m_mem[i] = '0;
            end
        end else if (clr_req) begin
            model_reset();
        end else begin
            if (m_wr_valid()) begin
                m_mem[a3] = wd3;
                m_pend[a3] = 0;
            end
            if (mark_en && mark_addr != 0) m_pend[mark_addr] = 1;
        end
    endtask

    task automatic idle();
        we = 0; a3 = '0; wd3 = '0; mark_en = 0; mark_addr = '0; clr_req = 0;
    endtask

    // Called at posedge+1 with inputs set; checks mid-cycle, then steps the edge.
    task automatic settle();
        #3;
    endtask

    task automatic cyc();
        chk("ready", {31'b0, ready}, {31'b0, m_ready});
        chk("rd1", rd1, m_rd(a1));
        chk("rd2", rd2, m_rd(a2));
        chk("rd1_busy", {31'b0, rd1_busy}, {31'b0, m_busy(a1)});
        chk("rd2_busy", {31'b0, rd2_busy}, {31'b0, m_busy(a2)});
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic step();
        settle();
        cyc();
    endtask

    vec_t vecs [12];

    initial begin
        vecs[0]  = '{1, 5, 32'hDEADBEEF, 5, 0, 0, 32'hDEADBEEF, 0};
        vecs[1]  = '{0, 0, 32'h0,        5, 0, 0, 32'hDEADBEEF, 0};
        vecs[2]  = '{1, 0, 32'h1234,     0, 0, 0, 32'h0,        0};
        vecs[3]  = '{0, 0, 32'h0,        0, 0, 0, 32'h0,        0};
        vecs[4]  = '{0, 0, 32'h0,        7, 1, 7, 32'h0,        0};
        vecs[5]  = '{0, 0, 32'h0,        7, 0, 0, 32'h0,        1};
        vecs[6]  = '{1, 7, 32'h55,       7, 0, 0, 32'h55,       0};
        vecs[7]  = '{0, 0, 32'h0,        7, 0, 0, 32'h55,       0};
        vecs[8]  = '{1, 7, 32'h66,       7, 1, 7, 32'h66,       0};
        vecs[9]  = '{0, 0, 32'h0,        7, 0, 0, 32'h66,       1};
        vecs[10] = '{0, 0, 32'h0,        0, 1, 0, 32'h0,        0};
        vecs[11] = '{0, 0, 32'h0,        0, 0, 0, 32'h0,        0};

        idle();
        a1 = 5'd3; a2 = 5'd9;
        rst_n = 0;
        model_reset();
        #2;
        chk("reset_ready", {31'b0, ready}, 32'h0);
        chk("reset_rd1", rd1, 32'h0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1;

        // Sweep: ready low for 31 edges, high after the 32nd.
        for (int i = 1; i <= DEPTH; i++) begin
            a1 = AW'(i); a2 = AW'(i + 3);
            step();
            if (i == DEPTH - 1) chk("sweep_ready_31", {31'b0, ready}, 32'h0);
        end
        chk("sweep_ready_32", {31'b0, ready}, 32'h1);

        // Directed table: bypass, zero register, scoreboard mark/write ordering.
        for (int i = 0; i < 12; i++) begin
            idle();
            we = vecs[i].we; a3 = vecs[i].a3; wd3 = vecs[i].wd3;
            a1 = vecs[i].a1; a2 = 5'd5;
            mark_en = vecs[i].mark_en; mark_addr = vecs[i].mark_addr;
            settle();
            chk($sformatf("vec%0d_rd1", i), rd1, vecs[i].exp_rd1);
            chk($sformatf("vec%0d_busy1", i), {31'b0, rd1_busy}, {31'b0, vecs[i].exp_busy1});
            cyc();
        end

        // Clear sweep after a write and a mark; contents and pending flags wiped.
        idle(); we = 1; a3 = 9; wd3 = 32'hAA; a1 = 9; a2 = 3;
        step();
        idle(); mark_en = 1; mark_addr = 3;
        step();
        idle(); clr_req = 1; we = 1; a3 = 12; wd3 = 32'h77; mark_en = 1; mark_addr = 12;
        step();
        idle(); a1 = 9; a2 = 3;
        chk("clr_ready_low", {31'b0, ready}, 32'h0);
        for (int i = 1; i <= DEPTH; i++) step();
        chk("clr_ready_high", {31'b0, ready}, 32'h1);
        settle();
        chk("clr_reg9", rd1, 32'h0);
        chk("clr_pend3", {31'b0, rd2_busy}, 32'h0);
        a1 = 12; a2 = 12;
        step();
        chk("clr_dropped_wr", rd1, 32'h0);
        chk("clr_dropped_mark", {31'b0, rd1_busy}, 32'h0);

        // Async reset in the middle of a sweep restarts it from the beginning.
        idle(); clr_req = 1;
        step();
        idle();
        for (int i = 0; i < 10; i++) step();
        #1 rst_n = 0;
        #1;
        chk("midreset_ready", {31'b0, ready}, 32'h0);
        chk("midreset_rd1", rd1, 32'h0);
        chk("midreset_busy", {31'b0, rd1_busy}, 32'h0);
        model_reset();
        @(posedge clk);
        #1 rst_n = 1;
        for (int i = 1; i <= DEPTH; i++) begin
            step();
            if (i == DEPTH - 1) chk("resweep_ready_31", {31'b0, ready}, 32'h0);
        end
        chk("resweep_ready_32", {31'b0, ready}, 32'h1);

        // Randomized traffic against the model; addresses biased onto the write target.
        for (int n = 0; n < 400; n++) begin
            idle();
            we = ($urandom_range(1) == 1);
            a3 = AW'($urandom_range(DEPTH - 1));
            wd3 = $urandom;
            mark_en = ($urandom_range(2) == 0);
            mark_addr = ($urandom_range(2) == 0) ? a3 : AW'($urandom_range(DEPTH - 1));
            a1 = ($urandom_range(2) == 0) ? a3 : AW'($urandom_range(DEPTH - 1));
            a2 = ($urandom_range(3) == 0) ? mark_addr : AW'($urandom_range(DEPTH - 1));
            clr_req = ($urandom_range(99) == 0);
            step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, expected completion");
        $fatal(1, "timeout");
    end

endmodule
